// File: rtl/psum_acc_requant.sv
// Channel-wise psum accumulator with bias, rounding requant, ReLU and
// saturation; streams one result per output element over valid/ready.
module psum_acc_requant #(
    parameter int PSUM_W    = 8,
    parameter int ACC_W     = 20,
    parameter int OUT_W     = 8,
    parameter int MAX_OFMAP = 1024,
    parameter int ADDR_W    = $clog2(MAX_OFMAP),
    parameter int CH_W      = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_start_i,
    input  logic [ADDR_W-1:0]        cfg_ofmap_size_i,
    input  logic [CH_W-1:0]          cfg_ifmap_ch_i,
    input  logic signed [ACC_W-1:0]  cfg_bias_i,
    input  logic [4:0]               cfg_shift_i,
    input  logic                     cfg_relu_i,
    input  logic signed [PSUM_W-1:0] psum_i,
    input  logic                     pvalid_i,
    output logic                     pready_o,
    output logic                     conv_valid_o,
    input  logic                     conv_ready_i,
    output logic signed [OUT_W-1:0]  conv_result_o,
    output logic                     last_o,
    output logic                     busy_o,
    output logic                     done_o
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    state_t state, state_nxt;

    logic [ADDR_W-1:0]       ofmap_q;
    logic [CH_W-1:0]         ch_q;
    logic signed [ACC_W-1:0] bias_q;
    logic [4:0]              shift_q;
    logic                    relu_q;
    logic [ADDR_W-1:0]       j_q;
    logic [CH_W-1:0]         c_q;

    logic signed [ACC_W-1:0] acc_buf [MAX_OFMAP];

    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? ACC_MIN : ACC_MAX;
        return s[ACC_W-1:0];
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_out(
        input logic signed [ACC_W-1:0] v
    );
        logic [ACC_W-OUT_W:0] hi;
        hi = v[ACC_W-1:OUT_W-1];
        if (&hi || ~|hi)
            return v[OUT_W-1:0];
        return v[ACC_W-1] ? OUT_MIN : OUT_MAX;
    endfunction

    logic                    start_ok;
    logic                    psum_xfer;
    logic                    out_xfer;
    logic                    last_ch;
    logic                    last_elem;
    logic signed [ACC_W-1:0] psum_ext;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] rsum;
    logic signed [ACC_W-1:0] rsh;
    logic signed [ACC_W-1:0] rq;

    // done_o gates start so a new layer begins the cycle after the pulse
    assign start_ok  = (state == S_IDLE) && cfg_start_i && !done_o;
    assign last_ch   = (c_q == ch_q);
    assign last_elem = (j_q == ofmap_q);
    assign pready_o  = (state == S_ACCUM) &&
                       (!last_ch || !conv_valid_o || conv_ready_i);
    assign psum_xfer = pvalid_i && pready_o;
    assign out_xfer  = conv_valid_o && conv_ready_i;
    assign busy_o    = (state != S_IDLE);

    // Channel 0 starts from the bias, so the buffer never needs clearing
    assign psum_ext = {{(ACC_W-PSUM_W){psum_i[PSUM_W-1]}}, psum_i};
    assign base     = (c_q == '0) ? bias_q : acc_buf[j_q];
    assign sum      = sat_add(base, psum_ext);
    assign rnd      = (shift_q != 5'd0) ?
                      (ACC_W'(1) << (shift_q - 5'd1)) : '0;
    assign rsum     = sat_add(sum, rnd);
    assign rsh      = rsum >>> shift_q;
    assign rq       = (relu_q && rsh[ACC_W-1]) ? '0 : rsh;

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start_ok) state_nxt = S_ACCUM;
            S_ACCUM: if (psum_xfer && last_ch && last_elem)
                         state_nxt = S_DONE;
            S_DONE:  if (out_xfer && last_o) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ofmap_q <= '0;
            ch_q    <= '0;
            bias_q  <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            j_q     <= '0;
            c_q     <= '0;
        end else if (start_ok) begin
            ofmap_q <= cfg_ofmap_size_i;
            ch_q    <= cfg_ifmap_ch_i;
            bias_q  <= cfg_bias_i;
            shift_q <= cfg_shift_i;
            relu_q  <= cfg_relu_i;
            j_q     <= '0;
            c_q     <= '0;
        end else if (psum_xfer) begin
            if (last_elem) begin
                j_q <= '0;
                c_q <= c_q + 1'b1;
            end else begin
                j_q <= j_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (psum_xfer && !last_ch)
            acc_buf[j_q] <= sum;
    end

    // A load can only happen when the slot is empty or draining this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            conv_valid_o  <= 1'b0;
            conv_result_o <= '0;
            last_o        <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            done_o <= (state == S_DONE) && out_xfer && last_o;
            if (psum_xfer && last_ch) begin
                conv_valid_o  <= 1'b1;
                conv_result_o <= sat_out(rq);
                last_o        <= last_elem;
            end else if (out_xfer) begin
                conv_valid_o  <= 1'b0;
            end
        end
    end

endmodule
